// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential divider: default operand widths and FSM encodings.
package seq_divider_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_VW = 4;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_BUSY = 2'd1;
  localparam state_t S_DONE = 2'd2;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial
// remainder with a parallel-prefix adder and keep the difference only when it does not borrow.
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   r_shifted,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  localparam int N = VW + 1;

  logic [N-1:0]  sub_b;
  logic [N-1:0]  gen;
  logic [N-1:0]  prop;
  logic [N-1:0]  pre_g;
  logic [N-1:0]  carry;
  logic [VW-1:0] diff;

  // a - b computed as a + ~b + 1
  assign sub_b = ~{1'b0, d};

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_gp
      assign gen[gi]  = r_shifted[gi] & sub_b[gi];
      assign prop[gi] = r_shifted[gi] ^ sub_b[gi];
    end
  endgenerate

  // Kogge-Stone prefix; the +1 carry-in is folded into bit 0's generate term.
  always_comb begin : prefix
    logic [N-1:0] gg;
    logic [N-1:0] pp;
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    gg    = gen;
    gg[0] = gen[0] | prop[0];
    pp    = prop;
    for (int s = 1; s < N; s = s * 2) begin
      gn = gg;
      pn = pp;
      for (int i = s; i < N; i++) begin
        gn[i] = gg[i] | (pp[i] & gg[i-s]);
        pn[i] = pp[i] & pp[i-s];
      end
      gg = gn;
      pp = pn;
    end
    pre_g = gg;
  end

  assign carry = {pre_g[N-2:0], 1'b1};

  generate
    for (gi = 0; gi < VW; gi++) begin : g_sum
      assign diff[gi] = prop[gi] ^ carry[gi];
    end
  endgenerate

  // Carry out of the MSB means no borrow: the divisor fits.
  assign q_bit  = pre_g[N-1];
  assign r_next = q_bit ? {1'b0, diff} : r_shifted;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider with valid/ready handshakes on operands and results;
// one quotient bit is resolved per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = $clog2(DW + 1);

  state_t        state_reg;
  logic [CW-1:0] count_reg;
  logic [VW:0]   r_reg;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic          zero_reg;

  logic [VW:0]   r_shifted;
  logic [VW:0]   r_step;
  logic          q_bit;
  logic [DW-1:0] q_next;
  logic          last_step;
  logic          unused_bits;

  assign r_shifted = {r_reg[VW-1:0], q_reg[DW-1]};
  assign q_next    = {q_reg[DW-2:0], q_bit};
  assign last_step = (count_reg == CW'(DW - 1));

  div_step #(.VW(VW)) u_step (
    .r_shifted (r_shifted),
    .d         (d_reg),
    .r_next    (r_step),
    .q_bit     (q_bit)
  );

  // The staging MSB of R is always zero after a step.
  assign unused_bits = r_step[VW] ^ r_reg[VW];

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      count_reg <= '0;
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      zero_reg  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            r_reg     <= '0;
            q_reg     <= dividend;
            d_reg     <= divisor;
            count_reg <= '0;
            zero_reg  <= (divisor == '0);
            state_reg <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A zero divisor spends a single cycle here so its result lands one edge after accept.
          if (zero_reg) begin
            quotient  <= '1;
            remainder <= '0;
            div_zero  <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            r_reg     <= r_step;
            q_reg     <= q_next;
            count_reg <= count_reg + 1'b1;
            if (last_step) begin
              quotient  <= q_next;
              remainder <= r_step[VW-1:0];
              div_zero  <= 1'b0;
              state_reg <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
